// File: rtl/inferred_sram_dp.sv
// inferred_sram_dp: registered-input 1RW+1R SRAM, byte lanes, read pipe,
// port 1 write-first bypass, init engine. Option: INFERRED_SRAM_PARITY_EN
module inferred_sram_dp #(
  parameter int ASIZE = 8,
  parameter int DSIZE = 32,
  parameter int BSIZE = 8,
  parameter int RD_PIPE = 0,
  parameter logic [DSIZE-1:0] INIT_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   init_busy,
  input  logic                   cs0_n,
  input  logic                   we0_n,
  input  logic [DSIZE/BSIZE-1:0] be0_n,
  input  logic [ASIZE-1:0]       addr0,
  input  logic [DSIZE-1:0]       wdata0,
  output logic [DSIZE-1:0]       rdata0,
  output logic                   rvalid0,
  output logic                   perr0,
  input  logic                   cs1_n,
  input  logic [ASIZE-1:0]       addr1,
  output logic [DSIZE-1:0]       rdata1,
  output logic                   rvalid1,
  output logic                   perr1,
  output logic                   collision
);

  localparam int NB    = DSIZE / BSIZE;
  localparam int DEPTH = 2 ** ASIZE;
  localparam int NS    = RD_PIPE + 1;

  if (DSIZE % BSIZE != 0) begin : g_bad_dsize
    $error("DSIZE must be a multiple of BSIZE");
  end

  if (RD_PIPE < 0 || RD_PIPE > 3) begin : g_bad_pipe
    $error("RD_PIPE must be 0..3");
  end

  typedef enum logic {
    S_INIT,
    S_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [ASIZE-1:0] init_addr_q, init_addr_d;

  logic             cs0_q, we0_q, cs1_q;
  logic [NB-1:0]    be0_q;
  logic [ASIZE-1:0] addr0_q, addr1_q;
  logic [DSIZE-1:0] wdata0_q;

  logic             rd0, wr0, rd1;
  logic [NB-1:0]    lane_we;
  logic [ASIZE-1:0] w_addr;
  logic [DSIZE-1:0] w_data;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [DSIZE-1:0] old0, old1, rd1_data;
  logic [NB-1:0]    byp;
  logic             perr0_a, perr1_a;

  logic [DSIZE-1:0] d0_q [NS];
  logic [DSIZE-1:0] d1_q [NS];
  logic [NS-1:0]    v0_q, p0_q;
  logic [NS-1:0]    v1_q, p1_q, c1_q;

  assign init_busy = (state_q == S_INIT);

  // init engine state and sweep address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // sweep every word once, then serve requests until the next reset
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    unique case (state_q)
      S_INIT: begin
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == '1) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // input registers; requests seen while busy are squashed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs0_q    <= 1'b1;
      we0_q    <= 1'b1;
      be0_q    <= '1;
      addr0_q  <= '0;
      wdata0_q <= '0;
      cs1_q    <= 1'b1;
      addr1_q  <= '0;
    end else begin
      cs0_q    <= init_busy | cs0_n;
      we0_q    <= we0_n;
      be0_q    <= be0_n;
      addr0_q  <= addr0;
      wdata0_q <= wdata0;
      cs1_q    <= init_busy | cs1_n;
      addr1_q  <= addr1;
    end
  end

  // decode registered request and pick the write source
  always_comb begin
    rd0     = !cs0_q && we0_q;
    wr0     = !cs0_q && !we0_q;
    rd1     = !cs1_q;
    lane_we = '0;
    if (init_busy) begin
      w_addr  = init_addr_q;
      w_data  = INIT_VAL;
      lane_we = '1;
    end else begin
      w_addr = addr0_q;
      w_data = wdata0_q;
      for (int i = 0; i < NB; i++) begin
        lane_we[i] = wr0 && !be0_q[i];
      end
    end
  end

  // storage array, lane-granular writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) begin
        mem[w_addr][i*BSIZE +: BSIZE] <= w_data[i*BSIZE +: BSIZE];
      end
    end
  end

  // array reads and write-first merge for port 1
  always_comb begin
    old0     = mem[addr0_q];
    old1     = mem[addr1_q];
    rd1_data = old1;
    byp      = '0;
    for (int i = 0; i < NB; i++) begin
      byp[i] = wr0 && rd1 && (addr0_q == addr1_q) && !be0_q[i];
      if (byp[i]) begin
        rd1_data[i*BSIZE +: BSIZE] = wdata0_q[i*BSIZE +: BSIZE];
      end
    end
  end

`ifdef INFERRED_SRAM_PARITY_EN
  logic [NB-1:0] pmem [DEPTH];
  logic [NB-1:0] wpar;

  // even parity per lane of the word being written
  always_comb begin
    wpar = '0;
    for (int i = 0; i < NB; i++) begin
      wpar[i] = ^w_data[i*BSIZE +: BSIZE];
    end
  end

  // parity array follows the data lane enables
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) begin
        pmem[w_addr][i] <= wpar[i];
      end
    end
  end

  // stored vs recomputed parity; bypassed lanes are fresh
  always_comb begin
    perr0_a = 1'b0;
    perr1_a = 1'b0;
    for (int i = 0; i < NB; i++) begin
      perr0_a = perr0_a |
        (pmem[addr0_q][i] ^ (^old0[i*BSIZE +: BSIZE]));
      if (!byp[i]) begin
        perr1_a = perr1_a |
          (pmem[addr1_q][i] ^ (^old1[i*BSIZE +: BSIZE]));
      end
    end
  end
`else
  assign perr0_a = 1'b0;
  assign perr1_a = 1'b0;
`endif

  // port 0 read pipe; data only moves with its valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= '0;
      p0_q <= '0;
      for (int s = 0; s < NS; s++) begin
        d0_q[s] <= '0;
      end
    end else begin
      v0_q[0] <= rd0;
      if (rd0) begin
        d0_q[0] <= old0;
        p0_q[0] <= perr0_a;
      end
      for (int s = 1; s < NS; s++) begin
        v0_q[s] <= v0_q[s-1];
        if (v0_q[s-1]) begin
          d0_q[s] <= d0_q[s-1];
          p0_q[s] <= p0_q[s-1];
        end
      end
    end
  end

  // port 1 read pipe with collision tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= '0;
      p1_q <= '0;
      c1_q <= '0;
      for (int s = 0; s < NS; s++) begin
        d1_q[s] <= '0;
      end
    end else begin
      v1_q[0] <= rd1;
      if (rd1) begin
        d1_q[0] <= rd1_data;
        p1_q[0] <= perr1_a;
        c1_q[0] <= |byp;
      end
      for (int s = 1; s < NS; s++) begin
        v1_q[s] <= v1_q[s-1];
        if (v1_q[s-1]) begin
          d1_q[s] <= d1_q[s-1];
          p1_q[s] <= p1_q[s-1];
          c1_q[s] <= c1_q[s-1];
        end
      end
    end
  end

  assign rdata0    = d0_q[NS-1];
  assign rvalid0   = v0_q[NS-1];
  assign perr0     = p0_q[NS-1] & v0_q[NS-1];
  assign rdata1    = d1_q[NS-1];
  assign rvalid1   = v1_q[NS-1];
  assign perr1     = p1_q[NS-1] & v1_q[NS-1];
  assign collision = c1_q[NS-1] & v1_q[NS-1];

endmodule

// File: tb/tb_inferred_sram_dp.sv
// tb_inferred_sram_dp: randomized bench for inferred_sram_dp
// against a word-level array model.
module tb_inferred_sram_dp;

  localparam int ASIZE = 4;
  localparam int DSIZE = 32;
  localparam int BSIZE = 8;
  localparam int NB    = 4;
  localparam int RDP   = 2;
  localparam int DEPTH = 16;
  localparam int LAT   = RDP + 2;
  localparam logic [31:0] IV = 32'hA5A5A5A5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             init_busy;
  logic             cs0_n = 1'b1, we0_n = 1'b1, cs1_n = 1'b1;
  logic [NB-1:0]    be0_n = '1;
  logic [ASIZE-1:0] addr0 = '0, addr1 = '0;
  logic [DSIZE-1:0] wdata0 = '0;
  logic [DSIZE-1:0] rdata0, rdata1;
  logic             rvalid0, rvalid1, perr0, perr1, collision;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] mdl [DEPTH];
  bit          ev0 [8];
  bit          ev1 [8];
  bit          ec1 [8];
  logic [31:0] ed0 [8];
  logic [31:0] ed1 [8];
  logic [31:0] hold0, hold1;

  inferred_sram_dp #(
    .ASIZE(ASIZE), .DSIZE(DSIZE), .BSIZE(BSIZE),
    .RD_PIPE(RDP), .INIT_VAL(IV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_busy(init_busy),
    .cs0_n(cs0_n), .we0_n(we0_n), .be0_n(be0_n),
    .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0),
    .rvalid0(rvalid0), .perr0(perr0),
    .cs1_n(cs1_n), .addr1(addr1), .rdata1(rdata1),
    .rvalid1(rvalid1), .perr1(perr1), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = IV;
    for (int i = 0; i < 8; i++) begin
      ev0[i] = 0; ev1[i] = 0; ec1[i] = 0;
      ed0[i] = '0; ed1[i] = '0;
    end
    hold0 = '0;
    hold1 = '0;
  endtask

  // apply a request and predict what it produces LAT edges later
  task automatic drive(input logic c0n, input logic w0n,
                       input logic [NB-1:0] b0n,
                       input logic [ASIZE-1:0] a0,
                       input logic [DSIZE-1:0] wd,
                       input logic c1n,
                       input logic [ASIZE-1:0] a1);
    int s;
    logic [31:0] d;
    bit c;
    s = (cyc + LAT) % 8;
    cs0_n = c0n; we0_n = w0n; be0_n = b0n;
    addr0 = a0; wdata0 = wd; cs1_n = c1n; addr1 = a1;
    if (!init_busy) begin
      if (!c0n && w0n) begin
        ev0[s] = 1; ed0[s] = mdl[a0];
      end
      if (!c1n) begin
        d = mdl[a1];
        c = 0;
        if (!c0n && !w0n && a0 == a1) begin
          for (int i = 0; i < NB; i++) begin
            if (!b0n[i]) begin
              d[i*8 +: 8] = wd[i*8 +: 8];
              c = 1;
            end
          end
        end
        ev1[s] = 1; ed1[s] = d; ec1[s] = c;
      end
      if (!c0n && !w0n) begin
        for (int i = 0; i < NB; i++) begin
          if (!b0n[i]) mdl[a0][i*8 +: 8] = wd[i*8 +: 8];
        end
      end
    end
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, '1, '0, '0, 1'b1, '0);
  endtask

  task automatic tick();
    ev0[cyc%8] = 0; ev1[cyc%8] = 0; ec1[cyc%8] = 0;
    @(posedge clk);
    #1;
    cyc++;
    if (ev0[cyc%8]) hold0 = ed0[cyc%8];
    if (ev1[cyc%8]) hold1 = ed1[cyc%8];
  endtask

  task automatic test_reset();
    int n;
    #3 rst_n = 1'b0;
    model_reset();
    idle();
    tick();
    n_cmp++;
    if ({rvalid0, rvalid1, perr0, perr1, collision, init_busy}
        !== 6'b000001) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000001",
        {rvalid0, rvalid1, perr0, perr1, collision, init_busy});
    end
    n_cmp++;
    if (rdata0 !== '0 || rdata1 !== '0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", rdata0, rdata1);
    end
    rst_n = 1'b1;
    n = 0;
    while (init_busy === 1'b1 && n < 64) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != 16) begin
      n_err++;
      $display("FAIL init_busy_len: got %0d want 16", n);
    end
  endtask

  task automatic test_init_contents();
    for (int i = 0; i < DEPTH + LAT; i++) begin
      if (i < DEPTH)
        drive(1'b0, 1'b1, '1, 4'(i), '0, 1'b0, 4'(DEPTH-1-i));
      else
        idle();
      tick();
      n_cmp++;
      if (rvalid0 !== ev0[cyc%8] || rdata0 !== hold0) begin
        n_err++;
        $display("FAIL init_rd0 @%0d: got %b/%h want %b/%h",
          cyc, rvalid0, rdata0, ev0[cyc%8], hold0);
      end
      n_cmp++;
      if (rvalid1 !== ev1[cyc%8] || rdata1 !== hold1) begin
        n_err++;
        $display("FAIL init_rd1 @%0d: got %b/%h want %b/%h",
          cyc, rvalid1, rdata1, ev1[cyc%8], hold1);
      end
    end
  endtask

  task automatic test_byte_enable();
    int r;
    drive(1'b0, 1'b0, 4'b0000, 4'd3, 32'h0, 1'b1, '0);
    tick();
    drive(1'b0, 1'b0, 4'b0101, 4'd3, 32'h11223344, 1'b1, '0);
    tick();
    drive(1'b0, 1'b1, '1, 4'd3, '0, 1'b1, '0);
    r = cyc;
    tick();
    idle();
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick();
      n_cmp++;
      if (rvalid0 !== (cyc == r + LAT)) begin
        n_err++;
        $display("FAIL be_latency k=%0d: got %b want %b",
          k, rvalid0, (cyc == r + LAT));
      end
      n_cmp++;
      if (rdata0 !== hold0) begin
        n_err++;
        $display("FAIL be_hold k=%0d: got %h want %h", k, rdata0, hold0);
      end
      if (cyc == r + LAT) begin
        n_cmp++;
        if (rdata0 !== 32'h11003300) begin
          n_err++;
          $display("FAIL be_data: got %h want 11003300", rdata0);
        end
      end
    end
  endtask

  task automatic test_collision();
    int r;
    drive(1'b0, 1'b0, 4'b0000, 4'd5, 32'hDEADBEEF, 1'b0, 4'd5);
    r = cyc;
    tick();
    idle();
    repeat (LAT - 1) tick();
    n_cmp++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'hDEADBEEF || collision !== 1'b1) begin
      n_err++;
      $display("FAIL coll_hit: got %b/%h/%b want 1/deadbeef/1",
        rvalid1, rdata1, collision);
    end
    drive(1'b0, 1'b0, 4'b0000, 4'd5, 32'h01020304, 1'b0, 4'd6);
    tick();
    idle();
    repeat (LAT - 1) tick();
    n_cmp++;
    if (rvalid1 !== 1'b1 || rdata1 !== hold1 || collision !== 1'b0) begin
      n_err++;
      $display("FAIL coll_miss: got %b/%h/%b want 1/%h/0",
        rvalid1, rdata1, collision, hold1);
    end
    drive(1'b0, 1'b0, 4'b1111, 4'd5, 32'hFFFFFFFF, 1'b0, 4'd5);
    tick();
    idle();
    repeat (LAT - 1) tick();
    n_cmp++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h01020304 || collision !== 1'b0) begin
      n_err++;
      $display("FAIL coll_nobe: got %b/%h/%b want 1/01020304/0",
        rvalid1, rdata1, collision);
    end
  endtask

  task automatic test_back_to_back();
    int c0, c1, f0, f1, l0, l1;
    c0 = 0; c1 = 0; f0 = -1; f1 = -1; l0 = 0; l1 = 0;
    for (int i = 0; i < 8 + LAT + 2; i++) begin
      if (i < 8) drive(1'b0, 1'b1, '1, 4'(i), '0, 1'b0, 4'(i));
      else idle();
      tick();
      if (rvalid0 === 1'b1) begin
        c0++; l0 = cyc; if (f0 < 0) f0 = cyc;
      end
      if (rvalid1 === 1'b1) begin
        c1++; l1 = cyc; if (f1 < 0) f1 = cyc;
      end
      n_cmp++;
      if (rvalid0 !== ev0[cyc%8] || rdata0 !== hold0) begin
        n_err++;
        $display("FAIL b2b_rd0 @%0d: got %b/%h want %b/%h",
          cyc, rvalid0, rdata0, ev0[cyc%8], hold0);
      end
      n_cmp++;
      if (rvalid1 !== ev1[cyc%8] || rdata1 !== hold1) begin
        n_err++;
        $display("FAIL b2b_rd1 @%0d: got %b/%h want %b/%h",
          cyc, rvalid1, rdata1, ev1[cyc%8], hold1);
      end
    end
    n_cmp++;
    if (c0 != 8 || l0 - f0 != 7) begin
      n_err++;
      $display("FAIL b2b_p0: got %0d pulses span %0d want 8 span 7",
        c0, l0 - f0);
    end
    n_cmp++;
    if (c1 != 8 || l1 - f1 != 7) begin
      n_err++;
      $display("FAIL b2b_p1: got %0d pulses span %0d want 8 span 7",
        c1, l1 - f1);
    end
  endtask

  task automatic test_random();
    logic c0n, w0n, c1n;
    logic [NB-1:0] b0n;
    logic [ASIZE-1:0] a0, a1;
    for (int i = 0; i < 300 + LAT; i++) begin
      if (i < 300) begin
        c0n = ($urandom_range(0, 3) == 0);
        w0n = 1'($urandom_range(0, 1));
        b0n = 4'($urandom());
        a0  = 4'($urandom());
        a1  = ($urandom_range(0, 1) == 1) ? a0 : 4'($urandom());
        c1n = ($urandom_range(0, 3) == 0);
        drive(c0n, w0n, b0n, a0, $urandom(), c1n, a1);
      end else begin
        idle();
      end
      tick();
      n_cmp++;
      if (rvalid0 !== ev0[cyc%8] || rdata0 !== hold0 || perr0 !== 1'b0) begin
        n_err++;
        $display("FAIL rnd_p0 @%0d: got %b/%h/%b want %b/%h/0",
          cyc, rvalid0, rdata0, perr0, ev0[cyc%8], hold0);
      end
      n_cmp++;
      if (rvalid1 !== ev1[cyc%8] || rdata1 !== hold1 ||
          collision !== ec1[cyc%8] || perr1 !== 1'b0) begin
        n_err++;
        $display("FAIL rnd_p1 @%0d: got %b/%h/%b/%b want %b/%h/%b/0",
          cyc, rvalid1, rdata1, collision, perr1,
          ev1[cyc%8], hold1, ec1[cyc%8]);
      end
    end
  endtask

  task automatic test_init_drop();
    int n;
    int r;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    repeat (4) tick();
    drive(1'b0, 1'b0, 4'b0000, 4'd2, 32'h0BADF00D, 1'b0, 4'd2);
    tick();
    drive(1'b0, 1'b1, '1, 4'd2, '0, 1'b1, '0);
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
        n_err++;
        $display("FAIL drop_rvalid k=%0d: got %b/%b want 0/0",
          k, rvalid0, rvalid1);
      end
    end
    n = 0;
    while (init_busy === 1'b1 && n < 64) begin
      tick();
      n++;
    end
    drive(1'b0, 1'b1, '1, 4'd2, '0, 1'b1, '0);
    r = cyc;
    tick();
    idle();
    repeat (LAT - 1) tick();
    n_cmp++;
    if (cyc != r + LAT || rvalid0 !== 1'b1 || rdata0 !== IV) begin
      n_err++;
      $display("FAIL drop_write: got %b/%h want 1/%h", rvalid0, rdata0, IV);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    repeat (6) tick();
    rst_n = 1'b0;
    n_cmp++;
    if (init_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midinit_busy: got %b want 1", init_busy);
    end
    tick();
    rst_n = 1'b1;
    n = 0;
    while (init_busy === 1'b1 && n < 64) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != 16) begin
      n_err++;
      $display("FAIL midinit_len: got %0d want 16", n);
    end
  endtask

  task automatic test_parity();
    logic exp2;
`ifdef INFERRED_SRAM_PARITY_EN
    dut.mem[2] = dut.mem[2] ^ 32'h1;
    mdl[2] = mdl[2] ^ 32'h1;
    exp2 = 1'b1;
`else
    exp2 = 1'b0;
`endif
    drive(1'b0, 1'b1, '1, 4'd2, '0, 1'b1, '0);
    tick();
    idle();
    repeat (LAT - 1) tick();
    n_cmp++;
    if (rvalid0 !== 1'b1 || perr0 !== exp2 || rdata0 !== hold0) begin
      n_err++;
      $display("FAIL par_a2: got %b/%b/%h want 1/%b/%h",
        rvalid0, perr0, rdata0, exp2, hold0);
    end
    drive(1'b0, 1'b1, '1, 4'd1, '0, 1'b1, '0);
    tick();
    idle();
    repeat (LAT - 1) tick();
    n_cmp++;
    if (rvalid0 !== 1'b1 || perr0 !== 1'b0 || rdata0 !== IV) begin
      n_err++;
      $display("FAIL par_a1: got %b/%b/%h want 1/0/%h",
        rvalid0, perr0, rdata0, IV);
    end
  endtask

  initial begin
    test_reset();
    test_init_contents();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_random();
    test_init_drop();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
